// File: rtl/store_narrow_if.sv
// Store-narrowing request/result bus: request side in, lane-aligned result out.
// slave = narrowing unit, master = EX stage / memory-side driver.
interface store_narrow_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic [1:0]  addr_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wmask_o;
  logic        ovf_o;
  logic        misalign_o;

  modport slave (
    input  in_valid_i, data_i, addr_i, size_i, signed_i, out_ready_i,
    output in_ready_o, out_valid_o, wdata_o, wmask_o, ovf_o, misalign_o
  );

  modport master (
    output in_valid_i, data_i, addr_i, size_i, signed_i, out_ready_i,
    input  in_ready_o, out_valid_o, wdata_o, wmask_o, ovf_o, misalign_o
  );
endinterface

// File: rtl/store_narrow.sv
// Store-path narrowing: byte/half/word lane placement, byte enables, overflow flag.
// Optional STORE_NARROW_SAT_EN: saturate overflowing narrow values instead of truncating.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no result held, always ready
// ST_FULL  | result held on outputs until out_ready_i
module store_narrow #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  store_narrow_if.slave        bus,
  input  logic                 clr_cnt_i,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wmask_q, wmask_d;
  logic                   ovf_q, ovf_d;
  logic                   mis_q, mis_d;
  logic [OVF_CNT_W-1:0]   cnt_q, cnt_d;

  logic        in_ready;
  logic        accept;
  logic        is_byte, is_half, is_word;
  logic        ovf_b, ovf_h;
  logic [31:0] ext_b, ext_h;
  logic [31:0] nval;

  always_comb begin
    is_byte = (bus.size_i == 2'b00);
    is_half = (bus.size_i == 2'b01);
    is_word = (bus.size_i == 2'b10);
    ext_b   = {{24{bus.data_i[7]}}, bus.data_i[7:0]};
    ext_h   = {{16{bus.data_i[15]}}, bus.data_i[15:0]};
    ovf_b   = bus.signed_i ? (ext_b != bus.data_i) : (|bus.data_i[31:8]);
    ovf_h   = bus.signed_i ? (ext_h != bus.data_i) : (|bus.data_i[31:16]);
    mis_d   = (bus.size_i == 2'b11) | (is_half & bus.addr_i[0]) |
              (is_word & (bus.addr_i != 2'b00));
    ovf_d   = !mis_d & ((is_byte & ovf_b) | (is_half & ovf_h));

    nval = 32'h0;
    if (is_byte)      nval = {24'h0, bus.data_i[7:0]};
    else if (is_half) nval = {16'h0, bus.data_i[15:0]};
    else if (is_word) nval = bus.data_i;
`ifdef STORE_NARROW_SAT_EN
    // Signed saturation direction follows the sign of the full register value.
    if (ovf_d) begin
      if (is_byte)
        nval = bus.signed_i ? (bus.data_i[31] ? 32'h80 : 32'h7F) : 32'hFF;
      else
        nval = bus.signed_i ? (bus.data_i[31] ? 32'h8000 : 32'h7FFF) : 32'hFFFF;
    end
`endif

    wdata_d = nval << {bus.addr_i, 3'b000};
    wmask_d = 4'b0000;
    if (is_byte)      wmask_d = 4'b0001 << bus.addr_i;
    else if (is_half) wmask_d = 4'b0011 << bus.addr_i;
    else if (is_word) wmask_d = 4'b1111;
    if (mis_d) begin
      wdata_d = 32'h0;
      wmask_d = 4'b0000;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_EMPTY) | bus.out_ready_i;
    accept   = bus.in_valid_i & in_ready;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)                state_d = ST_FULL;
        else if (bus.out_ready_i)  state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    cnt_d = cnt_q;
    if (clr_cnt_i)
      cnt_d = '0;
    else if (accept && ovf_d && !(&cnt_q))
      cnt_d = cnt_q + OVF_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      wdata_q <= 32'h0;
      wmask_q <= 4'b0000;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        ovf_q   <= ovf_d;
        mis_q   <= mis_d;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == ST_FULL);
  assign bus.wdata_o     = wdata_q;
  assign bus.wmask_o     = wmask_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.misalign_o  = mis_q;
  assign ovf_cnt_o       = cnt_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: vector table plus stall, counter and reset sequences.
module tb_store_narrow;

`ifdef STORE_NARROW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [1:0]  size;
    logic [1:0]  addr;
    logic        sgn;
    logic [31:0] data;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        ovf;
    logic        mis;
  } vec_t;

  localparam int NV = 14;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       clr_cnt_i = 1'b0;
  logic [7:0] ovf_cnt_o;
  int checks = 0;
  int failures = 0;
  vec_t vecs[NV];

  store_narrow_if bus();

  store_narrow #(.OVF_CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus.slave),
    .clr_cnt_i (clr_cnt_i),
    .ovf_cnt_o (ovf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic [1:0] size, logic [1:0] addr, logic sgn, logic [31:0] data,
                              logic [31:0] wdata, logic [3:0] mask, logic ovf, logic mis);
    vec_t v;
    v.size = size; v.addr = addr; v.sgn = sgn; v.data = data;
    v.wdata = wdata; v.mask = mask; v.ovf = ovf; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] size, input logic [1:0] addr, input logic sgn,
                       input logic [31:0] data);
    bus.in_valid_i = 1'b1;
    bus.size_i     = size;
    bus.addr_i     = addr;
    bus.signed_i   = sgn;
    bus.data_i     = data;
  endtask

  initial begin
    int exp_cnt;
    vecs[0]  = mk(2'b00, 2'd2, 1'b1, 32'h0000_0041, 32'h0041_0000, 4'b0100, 1'b0, 1'b0);
    vecs[1]  = mk(2'b01, 2'd2, 1'b1, 32'hFFFF_8000, 32'h8000_0000, 4'b1100, 1'b0, 1'b0);
    vecs[2]  = mk(2'b01, 2'd2, 1'b1, 32'h0000_8000, SAT ? 32'h7FFF_0000 : 32'h8000_0000, 4'b1100, 1'b1, 1'b0);
    vecs[3]  = mk(2'b01, 2'd1, 1'b0, 32'h0000_1234, 32'h0, 4'b0000, 1'b0, 1'b1);
    vecs[4]  = mk(2'b11, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 4'b0000, 1'b0, 1'b1);
    vecs[5]  = mk(2'b10, 2'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0);
    vecs[6]  = mk(2'b10, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 4'b0000, 1'b0, 1'b1);
    vecs[7]  = mk(2'b00, 2'd1, 1'b0, 32'h0000_0123, SAT ? 32'h0000_FF00 : 32'h0000_2300, 4'b0010, 1'b1, 1'b0);
    vecs[8]  = mk(2'b00, 2'd0, 1'b1, 32'hFFFF_FF80, 32'h0000_0080, 4'b0001, 1'b0, 1'b0);
    vecs[9]  = mk(2'b00, 2'd0, 1'b1, 32'h0000_0080, SAT ? 32'h0000_007F : 32'h0000_0080, 4'b0001, 1'b1, 1'b0);
    vecs[10] = mk(2'b00, 2'd1, 1'b1, 32'hFFFF_FF00, SAT ? 32'h0000_8000 : 32'h0000_0000, 4'b0010, 1'b1, 1'b0);
    vecs[11] = mk(2'b01, 2'd0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 4'b0011, 1'b0, 1'b0);
    vecs[12] = mk(2'b01, 2'd2, 1'b0, 32'h0001_0000, SAT ? 32'hFFFF_0000 : 32'h0000_0000, 4'b1100, 1'b1, 1'b0);
    vecs[13] = mk(2'b00, 2'd3, 1'b0, 32'h0000_00AB, 32'hAB00_0000, 4'b1000, 1'b0, 1'b0);

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.data_i      = 32'h0;
    bus.addr_i      = 2'd0;
    bus.size_i      = 2'd0;
    bus.signed_i    = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
    chk("rst_wdata", bus.wdata_o, 32'h0);
    chk("rst_wmask", {28'h0, bus.wmask_o}, 32'h0);
    chk("rst_ovf_mis", {30'h0, bus.ovf_o, bus.misalign_o}, 32'h0);
    chk("rst_cnt", {24'h0, ovf_cnt_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // table, back-to-back with out_ready_i=1
    exp_cnt = 0;
    @(negedge clk_i);
    drive(vecs[0].size, vecs[0].addr, vecs[0].sgn, vecs[0].data);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      chk($sformatf("vec%0d_valid", i), {31'h0, bus.out_valid_o}, 32'h1);
      chk($sformatf("vec%0d_wdata", i), bus.wdata_o, vecs[i].wdata);
      chk($sformatf("vec%0d_wmask", i), {28'h0, bus.wmask_o}, {28'h0, vecs[i].mask});
      chk($sformatf("vec%0d_ovf", i), {31'h0, bus.ovf_o}, {31'h0, vecs[i].ovf});
      chk($sformatf("vec%0d_mis", i), {31'h0, bus.misalign_o}, {31'h0, vecs[i].mis});
      if (vecs[i].ovf) exp_cnt++;
      if (i + 1 < NV) drive(vecs[i+1].size, vecs[i+1].addr, vecs[i+1].sgn, vecs[i+1].data);
      else bus.in_valid_i = 1'b0;
    end
    chk("table_cnt", {24'h0, ovf_cnt_o}, exp_cnt);
    @(negedge clk_i);
    chk("drain_valid", {31'h0, bus.out_valid_o}, 32'h0);

    // stall: result held while out_ready_i=0
    bus.out_ready_i = 1'b0;
    drive(2'b00, 2'd2, 1'b1, 32'h0000_0041);
    @(negedge clk_i);
    chk("stall_valid", {31'h0, bus.out_valid_o}, 32'h1);
    chk("stall_in_ready", {31'h0, bus.in_ready_o}, 32'h0);
    drive(2'b10, 2'd0, 1'b0, 32'h1122_3344);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("hold%0d_wdata", k), bus.wdata_o, 32'h0041_0000);
      chk($sformatf("hold%0d_wmask", k), {28'h0, bus.wmask_o}, 32'h4);
      chk($sformatf("hold%0d_valid", k), {31'h0, bus.out_valid_o}, 32'h1);
      chk($sformatf("hold%0d_in_ready", k), {31'h0, bus.in_ready_o}, 32'h0);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("release_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("release_wdata", bus.wdata_o, 32'h1122_3344);
    chk("release_wmask", {28'h0, bus.wmask_o}, 32'hF);
    chk("release_valid", {31'h0, bus.out_valid_o}, 32'h1);
    @(negedge clk_i);
    chk("release_drain", {31'h0, bus.out_valid_o}, 32'h0);

    // counter
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    chk("cnt_clr", {24'h0, ovf_cnt_o}, 32'h0);
    drive(2'b00, 2'd0, 1'b1, 32'h0000_0080);
    repeat (3) @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("cnt_three", {24'h0, ovf_cnt_o}, 32'd3);
    clr_cnt_i = 1'b1;
    drive(2'b00, 2'd0, 1'b1, 32'h0000_0080);
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("cnt_clr_prio", {24'h0, ovf_cnt_o}, 32'h0);
    chk("clr_prio_ovf", {31'h0, bus.ovf_o}, 32'h1);
    drive(2'b00, 2'd2, 1'b1, 32'h0000_0041);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("cnt_no_ovf", {24'h0, ovf_cnt_o}, 32'h0);
    drive(2'b01, 2'd0, 1'b0, 32'h0001_0000);
    repeat (260) @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("cnt_sat", {24'h0, ovf_cnt_o}, 32'd255);

    // reset while stalled
    bus.out_ready_i = 1'b0;
    drive(2'b00, 2'd0, 1'b1, 32'h0000_0080);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("pre_rst_valid", {31'h0, bus.out_valid_o}, 32'h1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("async_rst_cnt", {24'h0, ovf_cnt_o}, 32'h0);
    chk("async_rst_wdata", bus.wdata_o, 32'h0);
    chk("async_rst_ovf", {31'h0, bus.ovf_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("post_rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
